mlsu_req_arbiter: RTL

- Shares the single MLSU request port (pe_req valid/ready/bits) between NrReq issue sources, for example the scalar-issued and matrix-issued request queues.
- Arbitration is round-robin.
- Enforces load/store memory ordering and per-class outstanding limits, using counters that drain on the MLSU load and store completion pulses.
- Sits directly upstream of the MLSU request input. It provides a single registered output stage.

---
 rtl/mlsu_req_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mlsu_req_arbiter.sv
// Round-robin arbiter sharing the MLSU request port, enforcing load/store ordering and outstanding limits.
// Latency: 1 cycle from grant to mlsu_req_valid_o through a single registered output slot.
// Backpressure: slot refills in the cycle it drains; req_ready_o stays 0 while the slot is full and stalled.
module mlsu_req_arbiter #(
    parameter int unsigned NrReq    = 2,
    parameter int unsigned ReqWidth = 128,
    parameter int unsigned MaxOutLd = 4,
    parameter int unsigned MaxOutSt = 4,
    parameter int unsigned CntW     = $clog2(((MaxOutLd > MaxOutSt) ? MaxOutLd : MaxOutSt) + 1),
    parameter int unsigned SrcW     = $clog2(NrReq)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NrReq-1:0]          req_valid_i,
    output logic [NrReq-1:0]          req_ready_o,
    input  logic [NrReq*ReqWidth-1:0] req_bits_i,
    input  logic [NrReq-1:0]          req_is_load_i,
    output logic                      mlsu_req_valid_o,
    input  logic                      mlsu_req_ready_i,
    output logic [ReqWidth-1:0]       mlsu_req_o,
    output logic [SrcW-1:0]           mlsu_req_src_o,
    input  logic                      ld_done_i,
    input  logic                      st_done_i,
    output logic [CntW-1:0]           ld_cnt_o,
    output logic [CntW-1:0]           st_cnt_o,
    output logic                      idle_o,
    output logic                      err_o
);

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    typedef struct packed {
        logic [SrcW-1:0]     src;
        logic [ReqWidth-1:0] dat;
    } slot_t;

    slot_state_e         state_q, state_d;
    slot_t               slot_q, slot_d;
    logic [SrcW-1:0]     rr_q, rr_d;
    logic [CntW-1:0]     ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
    logic                err_q, err_d;
    logic                slot_rdy, ld_ok, st_ok;
    logic                grant_vld, grant_fire, grant_is_load;
    logic [SrcW-1:0]     grant_idx;
    logic [SrcW:0]       cand;
    logic [NrReq-1:0]    eligible;
    logic [ReqWidth-1:0] bits_arr [NrReq];

    for (genvar g = 0; g < NrReq; g++) begin : g_unpack
        assign bits_arr[g] = req_bits_i[g*ReqWidth +: ReqWidth];
    end

    // Counters cover the request sitting in the slot, so only one class is ever in flight.
    assign ld_ok    = (st_cnt_q == '0) && (ld_cnt_q < CntW'(MaxOutLd));
    assign st_ok    = (ld_cnt_q == '0) && (st_cnt_q < CntW'(MaxOutSt));
    assign slot_rdy = (state_q == SLOT_EMPTY) || mlsu_req_ready_i;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            eligible[i] = req_valid_i[i] && (req_is_load_i[i] ? ld_ok : st_ok);
        end
    end

    // First eligible source at or after the pointer; ineligible sources are skipped.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NrReq; k++) begin
            cand = {1'b0, rr_q} + (SrcW+1)'(k);
            if (cand >= (SrcW+1)'(NrReq)) begin
                cand = cand - (SrcW+1)'(NrReq);
            end
            if (!grant_vld && eligible[cand[SrcW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[SrcW-1:0];
            end
        end
    end

    assign grant_fire    = rst_ni && slot_rdy && grant_vld;
    assign grant_is_load = req_is_load_i[grant_idx];

    always_comb begin
        req_ready_o = '0;
        if (grant_fire) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] c,
                                                 input logic inc, input logic dec);
        cnt_next = c;
        if (inc && !dec) begin
            cnt_next = c + 1'b1;
        end else if (dec && !inc && (c != '0)) begin
            cnt_next = c - 1'b1;
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        rr_d     = rr_q;
        if (grant_fire) begin
            state_d    = SLOT_FULL;
            slot_d.src = grant_idx;
            slot_d.dat = bits_arr[grant_idx];
            rr_d       = (grant_idx == SrcW'(NrReq - 1)) ? '0 : grant_idx + 1'b1;
        end else if ((state_q == SLOT_FULL) && mlsu_req_ready_i) begin
            state_d = SLOT_EMPTY;
        end
        ld_cnt_d = cnt_next(ld_cnt_q, grant_fire && grant_is_load, ld_done_i);
        st_cnt_d = cnt_next(st_cnt_q, grant_fire && !grant_is_load, st_done_i);
        err_d    = err_q || (ld_done_i && (ld_cnt_q == '0)) || (st_done_i && (st_cnt_q == '0));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= SLOT_EMPTY;
            slot_q   <= '0;
            rr_q     <= '0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            rr_q     <= rr_d;
            ld_cnt_q <= ld_cnt_d;
            st_cnt_q <= st_cnt_d;
            err_q    <= err_d;
        end
    end

    assign mlsu_req_valid_o = (state_q == SLOT_FULL);
    assign mlsu_req_o       = slot_q.dat;
    assign mlsu_req_src_o   = slot_q.src;
    assign ld_cnt_o         = ld_cnt_q;
    assign st_cnt_o         = st_cnt_q;
    assign err_o            = err_q;
    assign idle_o           = (state_q == SLOT_EMPTY) && (ld_cnt_q == '0) && (st_cnt_q == '0);

endmodule
